// File: rtl/tile_renderer_if.sv
// Bus bundle for tile_renderer: VGA timing in, tile-map and sprite SRAM ports,
// game-logic write handshake and the pixel stream out.
interface tile_renderer_if #(
  parameter int MAP_AW = 13,
  parameter int SPR_AW = 9,
  parameter int TILE_W = 3
);
  logic [9:0]        hcount_i;
  logic [9:0]        vcount_i;
  logic              active_i;
  logic              hsync_i;
  logic              vsync_i;
  logic [MAP_AW-1:0] map_addr_o;
  logic              map_write_o;
  logic [TILE_W-1:0] map_data_o;
  logic [TILE_W-1:0] map_data_i;
  logic [SPR_AW-1:0] spr_addr_o;
  logic              spr_data_i;
  logic              wr_req_i;
  logic [MAP_AW-1:0] wr_addr_i;
  logic [TILE_W-1:0] wr_data_i;
  logic              wr_ack_o;
  logic              pixel_o;
  logic [TILE_W-1:0] tile_o;
  logic              hsync_o;
  logic              vsync_o;
  logic              active_o;

  modport master (
    input  hcount_i, vcount_i, active_i, hsync_i, vsync_i,
    input  map_data_i, spr_data_i, wr_req_i, wr_addr_i, wr_data_i,
    output map_addr_o, map_write_o, map_data_o, spr_addr_o, wr_ack_o,
    output pixel_o, tile_o, hsync_o, vsync_o, active_o
  );

  modport slave (
    output hcount_i, vcount_i, active_i, hsync_i, vsync_i,
    output map_data_i, spr_data_i, wr_req_i, wr_addr_i, wr_data_i,
    input  map_addr_o, map_write_o, map_data_o, spr_addr_o, wr_ack_o,
    input  pixel_o, tile_o, hsync_o, vsync_o, active_o
  );
endinterface

// File: rtl/tile_renderer.sv
// Five-stage pixel pipeline: coordinate -> tile id (map SRAM) -> sprite bit (sprite SRAM).
// Owns the tile-map port and slips game-logic writes into blank input cycles.
module tile_renderer #(
  parameter int MAP_AW = 13,
  parameter int SPR_AW = 9,
  parameter int TILE_W = 3,
  parameter int N_SPR  = 6
) (
  input logic            clk,
  input logic            rst,
  tile_renderer_if.master bus
);

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       act;
    logic       hs;
    logic       vs;
  } crd_t;

  typedef struct packed {
    logic [TILE_W-1:0] id;
    logic              vis;
    logic              act;
    logic              hs;
    logic              vs;
  } tag_t;

  typedef struct packed {
    logic              pixel;
    logic [TILE_W-1:0] tile;
    logic              hs;
    logic              vs;
    logic              act;
  } out_t;

  // Row*80 built from shifts; wraps at MAP_AW for out-of-frame blank coordinates.
  function automatic logic [MAP_AW-1:0] tile_index(input logic [9:0] h, input logic [9:0] v);
    logic [MAP_AW-1:0] r;
    r = MAP_AW'(v[9:3]);
    return (r << 6) + (r << 4) + MAP_AW'(h[9:3]);
  endfunction

  crd_t              s1_q, s1_d, s2_q, s2_d;
  tag_t              s3_q, s3_d, s4_q, s4_d;
  out_t              out_q, out_d;
  logic [MAP_AW-1:0] map_addr_q, map_addr_d;
  logic              map_write_q, map_write_d;
  logic [TILE_W-1:0] map_data_q, map_data_d;
  logic [SPR_AW-1:0] spr_addr_q, spr_addr_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_slot_s;
  logic              id_ok_s;

  // Next-state for every pipeline stage and the map-port arbitration.
  always_comb begin
    wr_slot_s = !bus.active_i && bus.wr_req_i;
    id_ok_s   = bus.map_data_i < TILE_W'(N_SPR);

    s1_d = '{row: bus.vcount_i[2:0], col: bus.hcount_i[2:0],
             act: bus.active_i, hs: bus.hsync_i, vs: bus.vsync_i};
    s2_d = s1_q;

    if (wr_slot_s) begin
      map_addr_d  = bus.wr_addr_i;
      map_write_d = 1'b1;
      map_data_d  = bus.wr_data_i;
    end else begin
      map_addr_d  = tile_index(bus.hcount_i, bus.vcount_i);
      map_write_d = 1'b0;
      map_data_d  = {TILE_W{1'b0}};
    end
    wr_ack_d = wr_slot_s;

    // A write slot always carries act=0, so it is masked like any blank pixel.
    s3_d = '{id: bus.map_data_i, vis: s2_q.act && id_ok_s,
             act: s2_q.act, hs: s2_q.hs, vs: s2_q.vs};
    if (s3_d.vis) begin
      spr_addr_d = SPR_AW'({bus.map_data_i, s2_q.row, s2_q.col});
    end else begin
      spr_addr_d = {SPR_AW{1'b0}};
    end
    s4_d = s3_q;

    out_d.pixel = s4_q.vis && bus.spr_data_i;
    if (s4_q.vis) begin
      out_d.tile = s4_q.id;
    end else begin
      out_d.tile = {TILE_W{1'b0}};
    end
    out_d.hs  = s4_q.hs;
    out_d.vs  = s4_q.vs;
    out_d.act = s4_q.act;
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      s4_q        <= '0;
      out_q       <= '0;
      map_addr_q  <= {MAP_AW{1'b0}};
      map_write_q <= 1'b0;
      map_data_q  <= {TILE_W{1'b0}};
      spr_addr_q  <= {SPR_AW{1'b0}};
      wr_ack_q    <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      s4_q        <= s4_d;
      out_q       <= out_d;
      map_addr_q  <= map_addr_d;
      map_write_q <= map_write_d;
      map_data_q  <= map_data_d;
      spr_addr_q  <= spr_addr_d;
      wr_ack_q    <= wr_ack_d;
    end
  end

  assign bus.map_addr_o  = map_addr_q;
  assign bus.map_write_o = map_write_q;
  assign bus.map_data_o  = map_data_q;
  assign bus.spr_addr_o  = spr_addr_q;
  assign bus.wr_ack_o    = wr_ack_q;
  assign bus.pixel_o     = out_q.pixel;
  assign bus.tile_o      = out_q.tile;
  assign bus.hsync_o     = out_q.hs;
  assign bus.vsync_o     = out_q.vs;
  assign bus.active_o    = out_q.act;

endmodule
